// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: signal bundle between the VGA timing generator and its
// consumers (pixel / framebuffer reader).
//
//   clk_en       global enable into the generator
//   pix_tick     one-cycle pixel enable (every DIV enabled clocks)
//   hsync/vsync  sync outputs, polarity set by the generator's SYNC_POL
//   video_on     high inside the visible 640x480 window
//   x, y         current pixel column / line
//   line_start   one-cycle pulse when x becomes 0
//   frame_start  one-cycle pulse when (x, y) becomes (0, 0)
//   frame_cnt    8-bit frame counter, only with VGA_FRAME_CNT_EN defined
//
// master: the timing generator.  slave: the consumer.
interface vga_sync_gen_if;
  logic       clk_en;
  logic       pix_tick;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;

  modport master (
    input  clk_en,
    output pix_tick, hsync, vsync, video_on, x, y, line_start, frame_start,
           frame_cnt
  );
  modport slave (
    output clk_en,
    input  pix_tick, hsync, vsync, video_on, x, y, line_start, frame_start,
           frame_cnt
  );
`else
  modport master (
    input  clk_en,
    output pix_tick, hsync, vsync, video_on, x, y, line_start, frame_start
  );
  modport slave (
    output clk_en,
    input  pix_tick, hsync, vsync, video_on, x, y, line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA 640x480@60 timing generator driven from the 100 MHz
// system clock.  A prescaler produces a one-cycle pixel enable (pix_tick)
// every DIV enabled clocks; no derived clock is used.
//
// Ports:
//   clk50Mhz  system clock (100 MHz on the current board)
//   rst       asynchronous, active-high reset
//   vga       vga_sync_gen_if.master: clk_en in; pix_tick, hsync, vsync,
//             video_on, x, y, line_start, frame_start (and frame_cnt) out
//
// Optional feature: define VGA_FRAME_CNT_EN to add the 8-bit wrapping
// frame counter (vga.frame_cnt), bumped on the edge that raises frame_start.
//
// Reset parks the counters on the last blanking pixel (H_TOTAL-1,
// V_TOTAL-1) so the first pixel tick after release lands on (0, 0) and
// raises frame_start.  All timing parameters must fit in 10 bits.
module vga_sync_gen #(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic           clk50Mhz,
  input  logic           rst,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0]    V_VIS     = 10'(V_ACTIVE);
  localparam logic [9:0]    HS_FIRST  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]    VS_FIRST  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [PW-1:0] prescaler;
  logic          tick;
  logic [9:0]    x_q, y_q;
  logic [9:0]    x_nxt, y_nxt;
  logic          hsync_q, vsync_q, video_on_q;
  logic          line_start_q, frame_start_q;
  logic          hs_win, vs_win, vis_nxt;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]    frame_cnt_q;
`endif

  assign tick = vga.clk_en && (prescaler == PRE_LAST);

  // Next raster position; outputs are decoded from this so that the
  // registered coordinates and the registered syncs/strobes always agree.
  always_comb begin
    x_nxt = x_q + 10'd1;
    y_nxt = y_q;
    if (x_q == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
  end

  assign hs_win  = (x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST);
  assign vs_win  = (y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST);
  assign vis_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);

  always_ff @(posedge clk50Mhz or posedge rst) begin
    if (rst) begin
      prescaler     <= '0;
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      // Strobes are single-cycle even if clk_en drops right after them.
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (vga.clk_en) begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
      end
      if (tick) begin
        x_q           <= x_nxt;
        y_q           <= y_nxt;
        hsync_q       <= hs_win ? SYNC_POL : ~SYNC_POL;
        vsync_q       <= vs_win ? SYNC_POL : ~SYNC_POL;
        video_on_q    <= vis_nxt;
        line_start_q  <= (x_nxt == 10'd0);
        frame_start_q <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
`ifdef VGA_FRAME_CNT_EN
        if ((x_nxt == 10'd0) && (y_nxt == 10'd0)) begin
          frame_cnt_q <= frame_cnt_q + 8'd1;
        end
`endif
      end
    end
  end

  assign vga.pix_tick    = tick;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
`ifdef VGA_FRAME_CNT_EN
  assign vga.frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen.  Two instances share clock, reset and clk_en:
// u0 with the default 640x480 timing, u1 with a tiny raster (8x6, DIV=2,
// active-high syncs) so whole frames and frame-counter wraps fit in a
// short run.  A reference model describes each instance by counting enabled
// cycles and pixel ticks since reset and mapping the tick count to a raster
// position with plain arithmetic.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen_if if0 ();
  vga_sync_gen_if if1 ();
  assign if0.clk_en = clk_en;
  assign if1.clk_en = clk_en;

  vga_sync_gen u0 (.clk50Mhz(clk), .rst(rst), .vga(if0.master));

  vga_sync_gen #(
    .DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) u1 (.clk50Mhz(clk), .rst(rst), .vga(if1.master));

  int P_DIV [2] = '{4, 2};
  int P_HA  [2] = '{640, 4};
  int P_HFP [2] = '{16, 1};
  int P_HS  [2] = '{96, 2};
  int P_HBP [2] = '{48, 1};
  int P_VA  [2] = '{480, 3};
  int P_VFP [2] = '{10, 1};
  int P_VS  [2] = '{2, 1};
  int P_VBP [2] = '{33, 1};
  int P_POL [2] = '{0, 1};

  int checks = 0;
  int failures = 0;

  int ecnt [2];
  int tcnt [2];
  int frames [2];
  bit prev_tick [2];
  bit tick_e [2];

  int a_tick [2], a_x [2], a_y [2], a_hs [2], a_vs [2];
  int a_vo [2], a_ls [2], a_fs [2], a_fc [2];

  typedef struct {
    bit en;
    int tick, x, y, vo, ls, fs, hs, vs;
  } vec_t;
  vec_t vecs [12];

  function automatic int ht(int i);
    return P_HA[i] + P_HFP[i] + P_HS[i] + P_HBP[i];
  endfunction
  function automatic int vt(int i);
    return P_VA[i] + P_VFP[i] + P_VS[i] + P_VBP[i];
  endfunction
  // Linear raster index after tcnt ticks; reset sits on the last pixel.
  function automatic int lin(int i);
    return (tcnt[i] + ht(i) * vt(i) - 1) % (ht(i) * vt(i));
  endfunction

  task automatic cmp(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ecnt[i] = 0; tcnt[i] = 0; frames[i] = 0; prev_tick[i] = 1'b0;
    end
  endtask

  task automatic sample();
    a_tick[0] = int'(if0.pix_tick); a_tick[1] = int'(if1.pix_tick);
    a_x[0] = int'(if0.x);           a_x[1] = int'(if1.x);
    a_y[0] = int'(if0.y);           a_y[1] = int'(if1.y);
    a_hs[0] = int'(if0.hsync);      a_hs[1] = int'(if1.hsync);
    a_vs[0] = int'(if0.vsync);      a_vs[1] = int'(if1.vsync);
    a_vo[0] = int'(if0.video_on);   a_vo[1] = int'(if1.video_on);
    a_ls[0] = int'(if0.line_start); a_ls[1] = int'(if1.line_start);
    a_fs[0] = int'(if0.frame_start); a_fs[1] = int'(if1.frame_start);
`ifdef VGA_FRAME_CNT_EN
    a_fc[0] = int'(if0.frame_cnt);  a_fc[1] = int'(if1.frame_cnt);
`else
    a_fc[0] = 0; a_fc[1] = 0;
`endif
  endtask

  task automatic model_check(input bit en);
    int l, ex, ey, hs_act, vs_act;
    sample();
    for (int i = 0; i < 2; i++) begin
      l  = lin(i);
      ex = l % ht(i);
      ey = l / ht(i);
      hs_act = (ex >= P_HA[i] + P_HFP[i]) && (ex < P_HA[i] + P_HFP[i] + P_HS[i]);
      vs_act = (ey >= P_VA[i] + P_VFP[i]) && (ey < P_VA[i] + P_VFP[i] + P_VS[i]);
      cmp("pix_tick", i, a_tick[i], int'(en && (ecnt[i] % P_DIV[i] == P_DIV[i] - 1)));
      cmp("x", i, a_x[i], ex);
      cmp("y", i, a_y[i], ey);
      cmp("hsync", i, a_hs[i], hs_act ? P_POL[i] : 1 - P_POL[i]);
      cmp("vsync", i, a_vs[i], vs_act ? P_POL[i] : 1 - P_POL[i]);
      cmp("video_on", i, a_vo[i], int'(ex < P_HA[i] && ey < P_VA[i]));
      cmp("line_start", i, a_ls[i], int'(prev_tick[i] && ex == 0));
      cmp("frame_start", i, a_fs[i], int'(prev_tick[i] && l == 0));
`ifdef VGA_FRAME_CNT_EN
      cmp("frame_cnt", i, a_fc[i], frames[i] % 256);
`endif
    end
  endtask

  // One clock: drive clk_en at the falling edge, check just after, then
  // advance the model across the rising edge.
  task automatic step(input bit en);
    @(negedge clk);
    clk_en = en;
    #1;
    model_check(en);
    for (int i = 0; i < 2; i++)
      tick_e[i] = en && (ecnt[i] % P_DIV[i] == P_DIV[i] - 1);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (tick_e[i]) begin
        tcnt[i]++;
        if (lin(i) == 0) frames[i]++;
      end
      if (en) ecnt[i]++;
      prev_tick[i] = tick_e[i];
    end
  endtask

  task automatic do_reset();
    clk_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  bit ok;
  int cnt, hs_low, vo_low, first_hs_x, ey0;

  initial begin
    //                 en tick   x    y  vo ls fs hs vs
    vecs[0]  = '{1'b1, 0, 799, 524, 0, 0, 0, 1, 1};
    vecs[1]  = '{1'b1, 0, 799, 524, 0, 0, 0, 1, 1};
    vecs[2]  = '{1'b1, 0, 799, 524, 0, 0, 0, 1, 1};
    vecs[3]  = '{1'b1, 1, 799, 524, 0, 0, 0, 1, 1};
    vecs[4]  = '{1'b0, 0,   0,   0, 1, 1, 1, 1, 1};
    vecs[5]  = '{1'b1, 0,   0,   0, 1, 0, 0, 1, 1};
    vecs[6]  = '{1'b1, 0,   0,   0, 1, 0, 0, 1, 1};
    vecs[7]  = '{1'b1, 0,   0,   0, 1, 0, 0, 1, 1};
    vecs[8]  = '{1'b1, 1,   0,   0, 1, 0, 0, 1, 1};
    vecs[9]  = '{1'b0, 0,   1,   0, 1, 0, 0, 1, 1};
    vecs[10] = '{1'b1, 0,   1,   0, 1, 0, 0, 1, 1};
    vecs[11] = '{1'b1, 0,   1,   0, 1, 0, 0, 1, 1};

    model_reset();
    repeat (3) @(negedge clk);
    #1;
    sample();
    cmp("rst_x", 0, a_x[0], 799);
    cmp("rst_y", 0, a_y[0], 524);
    cmp("rst_hsync", 0, a_hs[0], 1);
    cmp("rst_vsync", 0, a_vs[0], 1);
    cmp("rst_video_on", 0, a_vo[0], 0);
    cmp("rst_x", 1, a_x[1], 7);
    cmp("rst_y", 1, a_y[1], 5);
    cmp("rst_hsync", 1, a_hs[1], 0);
    @(negedge clk);
    rst = 1'b0;

    // Startup table on the default instance.
    for (int k = 0; k < 12; k++) begin
      step(vecs[k].en);
      cmp("vec_tick", k, a_tick[0], vecs[k].tick);
      cmp("vec_x", k, a_x[0], vecs[k].x);
      cmp("vec_y", k, a_y[0], vecs[k].y);
      cmp("vec_video_on", k, a_vo[0], vecs[k].vo);
      cmp("vec_line_start", k, a_ls[0], vecs[k].ls);
      cmp("vec_frame_start", k, a_fs[0], vecs[k].fs);
      cmp("vec_hsync", k, a_hs[0], vecs[k].hs);
      cmp("vec_vsync", k, a_vs[0], vecs[k].vs);
    end

    // One full line at full enable: period, hsync window, blanking span.
    ok = 0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      step(1'b1);
      if (a_ls[0] != 0) ok = 1;
    end
    cmp("line_start_wait", 0, int'(ok), 1);
    ey0 = lin(0) / ht(0);
    cnt = 0; hs_low = 0; vo_low = 0; first_hs_x = -1; ok = 0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      step(1'b1);
      cnt++;
      if (a_ls[0] != 0) ok = 1;
      else begin
        if (a_hs[0] == 0) begin
          hs_low++;
          if (first_hs_x < 0) first_hs_x = a_x[0];
        end
        if (a_vo[0] == 0) vo_low++;
      end
    end
    cmp("line_period_clk", 0, cnt, 3200);
    cmp("hsync_low_clk", 0, hs_low, 384);
    cmp("hsync_first_x", 0, first_hs_x, 656);
    cmp("video_off_clk", 0, vo_low, (ey0 < 480) ? 640 : 3199);

    // Freeze at x = 100 with clk_en low.
    ok = 0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      step(1'b1);
      if (a_x[0] == 100) ok = 1;
    end
    cmp("x100_wait", 0, int'(ok), 1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0);
      cmp("freeze_x", 0, a_x[0], 100);
      cmp("freeze_tick", 0, a_tick[0], 0);
    end
    ok = 0;
    for (int k = 0; k < 8 && !ok; k++) begin
      step(1'b1);
      if (a_x[0] != 100) ok = 1;
    end
    cmp("resume_x", 0, a_x[0], 101);

    // Small raster: frame_start period = 48 pixels * DIV 2.
    ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      step(1'b1);
      if (a_fs[1] != 0) ok = 1;
    end
    cmp("frame_start_wait", 1, int'(ok), 1);
    cnt = 0; ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      step(1'b1);
      cnt++;
      if (a_fs[1] != 0) ok = 1;
    end
    cmp("frame_period_clk", 1, cnt, 96);

    // Random enable pattern, model-checked every cycle.
    for (int k = 0; k < 3000; k++) step($urandom_range(0, 9) < 7);

    // Asynchronous reset in the middle of a line.
    ok = 0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      step(1'b1);
      if (a_x[0] == 300) ok = 1;
    end
    cmp("x300_wait", 0, int'(ok), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    sample();
    cmp("arst_x", 0, a_x[0], 799);
    cmp("arst_y", 0, a_y[0], 524);
    cmp("arst_hsync", 0, a_hs[0], 1);
    cmp("arst_vsync", 0, a_vs[0], 1);
    cmp("arst_video_on", 0, a_vo[0], 0);
    cmp("arst_tick", 0, a_tick[0], 0);
    clk_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      cmp("post_rst_no_tick", 0, a_tick[0], 0);
    end
    step(1'b1);
    cmp("post_rst_tick4", 0, a_tick[0], 1);
    step(1'b1);
    cmp("post_rst_frame_start", 0, a_fs[0], 1);
    cmp("post_rst_origin_x", 0, a_x[0], 0);

    for (int k = 0; k < 2000; k++) step($urandom_range(0, 3) != 0);

`ifdef VGA_FRAME_CNT_EN
    do_reset();
    for (int k = 0; k < 30000 && frames[1] < 257; k++) begin
      step(1'b1);
      if (a_fs[1] != 0 && frames[1] == 3) cmp("frame_cnt_after_3", 1, a_fc[1], 3);
      if (a_fs[1] != 0 && frames[1] == 256) cmp("frame_cnt_after_256", 1, a_fc[1], 0);
    end
    cmp("frame_cnt_run_done", 1, int'(frames[1] >= 257), 1);
`else
    do_reset();
    for (int k = 0; k < 200; k++) step($urandom_range(0, 1) != 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
